piso_tx_ctrl: RTL

Serial frame transmitter controller for the shift-register family. Accepts a parallel word over a valid/ready handshake and captures it into an internal parallel-load, enable-gated shift core. It sequences start, data (LSB first), optional parity and stop bits onto a single serial line, holding each bit for a programmable number of clock cycles. It sits between a parallel producer and an off-block serial link.

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_shift_core.sv | 23 ++
 rtl/piso_tx_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and line-level constants for the PISO serial transmitter family.
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;

  // Divider width; a 1-cycle bit still needs a 1-bit counter.
  function automatic int div_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit parallel-load, enable-gated right shifter; zero fill, async reset.
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         sr <= '0;
    else if (load)     sr <= d;
    else if (shift_en) sr <= sr >> 1;
  end

  assign q0 = sr[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serial frame transmitter: start, LSB-first data, optional even parity, stop.
// Optional parity bit is built in when PISO_TX_CTRL_PARITY_EN is defined.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int BIT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int DW = div_w(BIT_DIV);
  localparam int CW = $clog2(WIDTH + 1);

  tx_state_e       state, state_d;
  logic [DW-1:0]   div, div_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            tx_d, done_d;
  logic            load, shift_en, q0, bit_end;

  piso_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .d        (data_in),
    .q0       (q0)
  );

`ifdef PISO_TX_CTRL_PARITY_EN
  logic par;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     par <= 1'b0;
    else if (load) par <= ^data_in;
  end
`endif

  assign bit_end = (div == DW'(BIT_DIV - 1));

  // tx is registered from the next-state view, so the core shifts on the same
  // edge that tx takes a data bit: q0 always holds the next bit to send.
  always_comb begin
    state_d  = state;
    div_d    = div + DW'(1);
    cnt_d    = cnt;
    load     = 1'b0;
    shift_en = 1'b0;
    tx_d     = tx;
    case (state)
      IDLE: begin
        div_d = '0;
        tx_d  = TX_IDLE;
        if (data_valid && data_ready) begin
          load    = 1'b1;
          state_d = START;
          tx_d    = TX_START;
        end
      end
      START: if (bit_end) begin
        state_d  = DATA;
        div_d    = '0;
        cnt_d    = '0;
        tx_d     = q0;
        shift_en = 1'b1;
      end
      DATA: if (bit_end) begin
        div_d = '0;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
`ifdef PISO_TX_CTRL_PARITY_EN
          state_d = PARITY;
          tx_d    = par;
`else
          state_d = STOP;
          tx_d    = TX_IDLE;
`endif
        end else begin
          tx_d     = q0;
          shift_en = 1'b1;
        end
      end
`ifdef PISO_TX_CTRL_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        div_d   = '0;
        tx_d    = TX_IDLE;
      end
`endif
      STOP: if (bit_end) begin
        state_d = IDLE;
        div_d   = '0;
        tx_d    = TX_IDLE;
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        tx_d    = TX_IDLE;
      end
    endcase
    done_d = (state_d == STOP) && (div_d == DW'(BIT_DIV - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      cnt        <= '0;
      tx         <= TX_IDLE;
      data_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      div        <= div_d;
      cnt        <= cnt_d;
      tx         <= tx_d;
      data_ready <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      done       <= done_d;
    end
  end

endmodule
